// File: rtl/rtc_bcd_clock_if.sv
//------------------------------------------------------------------------------
// Module      : rtc_bcd_clock_if
// Description : Control, set, alarm and display bundle of the BCD clock.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface rtc_bcd_clock_if;
  logic       en;
  logic       mode_12h;
  logic       set_valid;
  logic [4:0] set_hr;
  logic [5:0] set_min;
  logic [5:0] set_sec;
  logic       alarm_en;
  logic [4:0] alarm_hr;
  logic [5:0] alarm_min;
  logic [6:0] hr_m;
  logic [6:0] hr_l;
  logic [6:0] min_m;
  logic [6:0] min_l;
  logic [6:0] sec_m;
  logic [6:0] sec_l;
  logic       pm;
  logic       sec_tick;
  logic       alarm_hit;
  logic       set_err;

  modport master (
    output en, mode_12h, set_valid, set_hr, set_min, set_sec,
           alarm_en, alarm_hr, alarm_min,
    input  hr_m, hr_l, min_m, min_l, sec_m, sec_l,
           pm, sec_tick, alarm_hit, set_err
  );

  modport slave (
    input  en, mode_12h, set_valid, set_hr, set_min, set_sec,
           alarm_en, alarm_hr, alarm_min,
    output hr_m, hr_l, min_m, min_l, sec_m, sec_l,
           pm, sec_tick, alarm_hit, set_err
  );
endinterface

`default_nettype wire

// File: rtl/rtc_bcd_clock.sv
//------------------------------------------------------------------------------
// Module      : rtc_bcd_clock
// Description : HH:MM:SS BCD clock with set, alarm, 12/24h seven-segment out.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rtc_bcd_clock #(
  parameter int unsigned CLK_DIV        = 50000000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  wire logic      clk,
  input  wire logic      rst,
  rtc_bcd_clock_if.slave bus
);

  localparam logic [31:0] c_div_last = 32'(CLK_DIV - 1);
  localparam logic [6:0]  c_blank_al = 7'b1111111;

  // Repeated subtraction keeps the 0-59 conversion free of a divider.
  function automatic logic [6:0] f_bin2bcd(input logic [5:0] v);
    logic [2:0] t;
    logic [5:0] u;
    t = 3'd0;
    u = v;
    for (int k = 0; k < 5; k++) begin
      if (u >= 6'd10) begin
        u = u - 6'd10;
        t = t + 3'd1;
      end
    end
    return {t, u[3:0]};
  endfunction

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = c_blank_al;
    endcase
    return s;
  endfunction

  logic [31:0] r_presc;
  logic [1:0]  r_hr_t;
  logic [3:0]  r_hr_u;
  logic [2:0]  r_min_t;
  logic [3:0]  r_min_u;
  logic [2:0]  r_sec_t;
  logic [3:0]  r_sec_u;
  logic        r_sec_tick;
  logic        r_alarm_hit;
  logic        r_set_err;

  logic        w_tick;
  logic        w_set_ok;
  logic [6:0]  w_set_hr_bcd;
  logic [6:0]  w_set_min_bcd;
  logic [6:0]  w_set_sec_bcd;
  logic        w_c_st, w_c_mu, w_c_mt, w_c_h;
  logic [1:0]  w_n_hr_t;
  logic [3:0]  w_n_hr_u;
  logic [2:0]  w_n_min_t;
  logic [3:0]  w_n_min_u;
  logic [2:0]  w_n_sec_t;
  logic [3:0]  w_n_sec_u;
  logic [4:0]  w_n_hr_bin;
  logic [5:0]  w_n_min_bin;
  logic        w_alarm_match;

  assign w_tick   = bus.en && (r_presc == c_div_last);
  assign w_set_ok = bus.set_valid && (bus.set_hr <= 5'd23) &&
                    (bus.set_min <= 6'd59) && (bus.set_sec <= 6'd59);

  assign w_set_hr_bcd  = f_bin2bcd({1'b0, bus.set_hr});
  assign w_set_min_bcd = f_bin2bcd(bus.set_min);
  assign w_set_sec_bcd = f_bin2bcd(bus.set_sec);

  // Ripple-carry chain through the six digit counters.
  assign w_c_st = (r_sec_u == 4'd9);
  assign w_c_mu = w_c_st && (r_sec_t == 3'd5);
  assign w_c_mt = w_c_mu && (r_min_u == 4'd9);
  assign w_c_h  = w_c_mt && (r_min_t == 3'd5);

  always_comb begin
    w_n_sec_u = w_c_st ? 4'd0 : r_sec_u + 4'd1;
    w_n_sec_t = r_sec_t;
    w_n_min_u = r_min_u;
    w_n_min_t = r_min_t;
    w_n_hr_t  = r_hr_t;
    w_n_hr_u  = r_hr_u;
    if (w_c_st) w_n_sec_t = (r_sec_t == 3'd5) ? 3'd0 : r_sec_t + 3'd1;
    if (w_c_mu) w_n_min_u = (r_min_u == 4'd9) ? 4'd0 : r_min_u + 4'd1;
    if (w_c_mt) w_n_min_t = (r_min_t == 3'd5) ? 3'd0 : r_min_t + 3'd1;
    if (w_c_h) begin
      if (r_hr_t == 2'd2 && r_hr_u == 4'd3) begin
        w_n_hr_t = 2'd0;
        w_n_hr_u = 4'd0;
      end else if (r_hr_u == 4'd9) begin
        w_n_hr_t = r_hr_t + 2'd1;
        w_n_hr_u = 4'd0;
      end else begin
        w_n_hr_u = r_hr_u + 4'd1;
      end
    end
  end

  // Next time is always legal, so out-of-range alarm fields can never match.
  assign w_n_hr_bin    = {3'd0, w_n_hr_t} * 5'd10 + {1'b0, w_n_hr_u};
  assign w_n_min_bin   = {3'd0, w_n_min_t} * 6'd10 + {2'd0, w_n_min_u};
  assign w_alarm_match = bus.alarm_en && (w_n_hr_bin == bus.alarm_hr) &&
                         (w_n_min_bin == bus.alarm_min) &&
                         (w_n_sec_t == 3'd0) && (w_n_sec_u == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc     <= '0;
      r_hr_t      <= '0;
      r_hr_u      <= '0;
      r_min_t     <= '0;
      r_min_u     <= '0;
      r_sec_t     <= '0;
      r_sec_u     <= '0;
      r_sec_tick  <= 1'b0;
      r_alarm_hit <= 1'b0;
      r_set_err   <= 1'b0;
    end else begin
      r_set_err <= bus.set_valid && !w_set_ok;
      if (w_set_ok) begin
        r_presc     <= '0;
        r_hr_t      <= w_set_hr_bcd[5:4];
        r_hr_u      <= w_set_hr_bcd[3:0];
        r_min_t     <= w_set_min_bcd[6:4];
        r_min_u     <= w_set_min_bcd[3:0];
        r_sec_t     <= w_set_sec_bcd[6:4];
        r_sec_u     <= w_set_sec_bcd[3:0];
        r_sec_tick  <= 1'b0;
        r_alarm_hit <= 1'b0;
      end else begin
        if (bus.en) r_presc <= w_tick ? '0 : r_presc + 32'd1;
        r_sec_tick  <= w_tick;
        r_alarm_hit <= w_tick && w_alarm_match;
        if (w_tick) begin
          r_hr_t  <= w_n_hr_t;
          r_hr_u  <= w_n_hr_u;
          r_min_t <= w_n_min_t;
          r_min_u <= w_n_min_u;
          r_sec_t <= w_n_sec_t;
          r_sec_u <= w_n_sec_u;
        end
      end
    end
  end

  logic [4:0] w_hr_bin;
  logic [4:0] w_hr12;
  logic [6:0] w_hr12_bcd;
  logic [3:0] w_hr_m_dig;
  logic [3:0] w_hr_l_dig;
  logic       w_hr_blank;
  logic [6:0] w_hr_m_al, w_hr_l_al, w_min_m_al, w_min_l_al, w_sec_m_al, w_sec_l_al;

  assign w_hr_bin   = {3'd0, r_hr_t} * 5'd10 + {1'b0, r_hr_u};
  assign w_hr12     = (w_hr_bin == 5'd0)  ? 5'd12 :
                      (w_hr_bin > 5'd12)  ? w_hr_bin - 5'd12 : w_hr_bin;
  assign w_hr12_bcd = f_bin2bcd({1'b0, w_hr12});
  assign w_hr_m_dig = bus.mode_12h ? {1'b0, w_hr12_bcd[6:4]} : {2'd0, r_hr_t};
  assign w_hr_l_dig = bus.mode_12h ? w_hr12_bcd[3:0] : r_hr_u;
  assign w_hr_blank = bus.mode_12h && (w_hr12_bcd[6:4] == 3'd0);

  assign w_hr_m_al  = w_hr_blank ? c_blank_al : f_seg(w_hr_m_dig);
  assign w_hr_l_al  = f_seg(w_hr_l_dig);
  assign w_min_m_al = f_seg({1'b0, r_min_t});
  assign w_min_l_al = f_seg(r_min_u);
  assign w_sec_m_al = f_seg({1'b0, r_sec_t});
  assign w_sec_l_al = f_seg(r_sec_u);

  generate
    if (SEG_ACTIVE_LOW) begin : g_seg_active_low
      assign bus.hr_m  = w_hr_m_al;
      assign bus.hr_l  = w_hr_l_al;
      assign bus.min_m = w_min_m_al;
      assign bus.min_l = w_min_l_al;
      assign bus.sec_m = w_sec_m_al;
      assign bus.sec_l = w_sec_l_al;
    end else begin : g_seg_active_high
      assign bus.hr_m  = ~w_hr_m_al;
      assign bus.hr_l  = ~w_hr_l_al;
      assign bus.min_m = ~w_min_m_al;
      assign bus.min_l = ~w_min_l_al;
      assign bus.sec_m = ~w_sec_m_al;
      assign bus.sec_l = ~w_sec_l_al;
    end
  endgenerate

  assign bus.pm        = bus.mode_12h && (w_hr_bin >= 5'd12);
  assign bus.sec_tick  = r_sec_tick;
  assign bus.alarm_hit = r_alarm_hit;
  assign bus.set_err   = r_set_err;

endmodule

`default_nettype wire

// File: tb/tb_rtc_bcd_clock.sv
//------------------------------------------------------------------------------
// Module      : tb_rtc_bcd_clock
// Description : Seconds-of-day reference model bench for rtc_bcd_clock.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rtc_bcd_clock;

  localparam int unsigned DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rtc_bcd_clock_if bus ();
  rtc_bcd_clock_if bus_ah ();

  assign bus_ah.en        = bus.en;
  assign bus_ah.mode_12h  = bus.mode_12h;
  assign bus_ah.set_valid = bus.set_valid;
  assign bus_ah.set_hr    = bus.set_hr;
  assign bus_ah.set_min   = bus.set_min;
  assign bus_ah.set_sec   = bus.set_sec;
  assign bus_ah.alarm_en  = bus.alarm_en;
  assign bus_ah.alarm_hr  = bus.alarm_hr;
  assign bus_ah.alarm_min = bus.alarm_min;

  rtc_bcd_clock #(.CLK_DIV(DIV), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  rtc_bcd_clock #(.CLK_DIV(DIV), .SEG_ACTIVE_LOW(1'b0)) dut_ah (
    .clk (clk),
    .rst (rst),
    .bus (bus_ah)
  );

  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100};

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  int m_tod;
  int m_pre;
  bit m_tick, m_hit, m_err;

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Time is one integer of seconds since midnight.
  always @(posedge clk) begin : p_model
    bit ok, tk;
    int nt, at;
    if (rst) begin
      m_tod  <= 0;
      m_pre  <= 0;
      m_tick <= 1'b0;
      m_hit  <= 1'b0;
      m_err  <= 1'b0;
    end else begin
      ok = bus.set_valid && bus.set_hr <= 23 && bus.set_min <= 59 && bus.set_sec <= 59;
      tk = bus.en && (m_pre == int'(DIV) - 1);
      nt = (m_tod + 1) % 86400;
      at = int'(bus.alarm_hr) * 3600 + int'(bus.alarm_min) * 60;
      m_err <= bus.set_valid && !ok;
      if (ok) begin
        m_tod  <= int'(bus.set_hr) * 3600 + int'(bus.set_min) * 60 + int'(bus.set_sec);
        m_pre  <= 0;
        m_tick <= 1'b0;
        m_hit  <= 1'b0;
      end else begin
        if (bus.en) m_pre <= tk ? 0 : m_pre + 1;
        if (tk) m_tod <= nt;
        m_tick <= tk;
        m_hit  <= tk && bus.alarm_en && bus.alarm_hr <= 23 && bus.alarm_min <= 59 && nt == at;
      end
    end
  end

  always @(negedge clk) begin : p_compare
    int h, mi, s, dh;
    bit b12;
    logic [6:0] e [6];
    if (chk_on) begin
      h   = m_tod / 3600;
      mi  = (m_tod / 60) % 60;
      s   = m_tod % 60;
      b12 = bus.mode_12h;
      dh  = b12 ? ((h % 12 == 0) ? 12 : h % 12) : h;
      e[0] = (b12 && dh / 10 == 0) ? 7'b1111111 : seg_tab[dh / 10];
      e[1] = seg_tab[dh % 10];
      e[2] = seg_tab[mi / 10];
      e[3] = seg_tab[mi % 10];
      e[4] = seg_tab[s / 10];
      e[5] = seg_tab[s % 10];
      chk("hr_m", bus.hr_m, e[0]);
      chk("hr_l", bus.hr_l, e[1]);
      chk("min_m", bus.min_m, e[2]);
      chk("min_l", bus.min_l, e[3]);
      chk("sec_m", bus.sec_m, e[4]);
      chk("sec_l", bus.sec_l, e[5]);
      chk("hr_m_ah", bus_ah.hr_m, ~e[0]);
      chk("hr_l_ah", bus_ah.hr_l, ~e[1]);
      chk("min_m_ah", bus_ah.min_m, ~e[2]);
      chk("min_l_ah", bus_ah.min_l, ~e[3]);
      chk("sec_m_ah", bus_ah.sec_m, ~e[4]);
      chk("sec_l_ah", bus_ah.sec_l, ~e[5]);
      chk("pm", {6'd0, bus.pm}, {6'd0, b12 && h >= 12});
      chk("sec_tick", {6'd0, bus.sec_tick}, {6'd0, m_tick});
      chk("alarm_hit", {6'd0, bus.alarm_hit}, {6'd0, m_hit});
      chk("set_err", {6'd0, bus.set_err}, {6'd0, m_err});
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_set(input int h, input int m, input int s);
    bus.set_hr    = 5'(h);
    bus.set_min   = 6'(m);
    bus.set_sec   = 6'(s);
    bus.set_valid = 1'b1;
    cyc(1);
    bus.set_valid = 1'b0;
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    while (bus.sec_tick !== 1'b1 && n < 20) begin
      cyc(1);
      n++;
    end
    chk("tick_seen", {6'd0, bus.sec_tick}, 7'd1);
  endtask

  initial begin
    int n;
    bus.en = 1'b1;
    bus.mode_12h = 1'b0;
    bus.set_valid = 1'b0;
    bus.set_hr = '0;
    bus.set_min = '0;
    bus.set_sec = '0;
    bus.alarm_en = 1'b0;
    bus.alarm_hr = '0;
    bus.alarm_min = '0;
    cyc(1);
    chk_on = 1'b1;
    cyc(2);
    chk("rst_hr_m", bus.hr_m, 7'b0000001);
    chk("rst_sec_l", bus.sec_l, 7'b0000001);
    rst = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      cyc(1);
      chk("tick_at_cycle", {6'd0, bus.sec_tick}, {6'd0, (c == 4 || c == 8)});
      if (c == 3) chk("sec_l_0", bus.sec_l, 7'b0000001);
      if (c == 4) chk("sec_l_1", bus.sec_l, 7'b1001111);
      if (c == 8) chk("sec_l_2", bus.sec_l, 7'b0010010);
    end

    do_set(23, 59, 59);
    wait_tick();
    chk("midnight_hr_m", bus.hr_m, 7'b0000001);
    chk("midnight_hr_l", bus.hr_l, 7'b0000001);
    chk("midnight_sec_l", bus.sec_l, 7'b0000001);
    bus.mode_12h = 1'b1;
    do_set(23, 59, 59);
    wait_tick();
    chk("midnight12_hr_m", bus.hr_m, 7'b1001111);
    chk("midnight12_hr_l", bus.hr_l, 7'b0010010);
    chk("midnight12_pm", {6'd0, bus.pm}, 7'd0);
    bus.mode_12h = 1'b0;

    do_set(24, 10, 0);
    chk("err_hr", {6'd0, bus.set_err}, 7'd1);
    cyc(1);
    chk("err_hr_once", {6'd0, bus.set_err}, 7'd0);
    do_set(5, 60, 0);
    chk("err_min", {6'd0, bus.set_err}, 7'd1);
    cyc(1);
    chk("err_min_once", {6'd0, bus.set_err}, 7'd0);

    n = 0;
    while (m_pre != int'(DIV) - 1 && n < 20) begin
      cyc(1);
      n++;
    end
    do_set(10, 20, 30);
    chk("settick_no_tick", {6'd0, bus.sec_tick}, 7'd0);
    chk("settick_hr_m", bus.hr_m, 7'b1001111);
    chk("settick_min_m", bus.min_m, 7'b0010010);
    chk("settick_sec_m", bus.sec_m, 7'b0000110);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (bus.sec_tick !== 1'b1 && n < 20);
    chk("settick_latency", 7'(n), 7'(DIV));
    chk("settick_sec_l", bus.sec_l, 7'b1001111);

    bus.mode_12h = 1'b1;
    do_set(13, 5, 0);
    chk("h12_hr_m", bus.hr_m, 7'b1111111);
    chk("h12_hr_l", bus.hr_l, 7'b1001111);
    chk("h12_pm", {6'd0, bus.pm}, 7'd1);
    chk("h12_hr_m_ah", bus_ah.hr_m, 7'b0000000);
    bus.mode_12h = 1'b0;

    bus.alarm_en = 1'b1;
    bus.alarm_hr = 5'd7;
    bus.alarm_min = 6'd30;
    do_set(7, 29, 59);
    wait_tick();
    chk("alarm_hit", {6'd0, bus.alarm_hit}, 7'd1);
    cyc(1);
    chk("alarm_once", {6'd0, bus.alarm_hit}, 7'd0);
    bus.en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cyc(1);
      chk("frozen_tick", {6'd0, bus.sec_tick}, 7'd0);
    end
    chk("frozen_min_l", bus.min_l, 7'b0000001);
    bus.en = 1'b1;
    do_set(7, 30, 0);
    for (int c = 0; c < 3; c++) begin
      chk("set_no_alarm", {6'd0, bus.alarm_hit}, 7'd0);
      cyc(1);
    end

    for (int i = 0; i < 4000; i++) begin
      rst           = ($urandom_range(0, 299) == 0);
      bus.en        = ($urandom_range(0, 9) != 0);
      bus.mode_12h  = 1'($urandom_range(0, 1));
      bus.alarm_en  = ($urandom_range(0, 7) != 0);
      bus.set_valid = ($urandom_range(0, 79) == 0);
      bus.set_hr    = 5'($urandom_range(0, 25));
      bus.set_min   = 6'($urandom_range(0, 61));
      bus.set_sec   = 6'($urandom_range(45, 61));
      if (bus.set_valid && $urandom_range(0, 1) == 1) begin
        bus.alarm_hr  = bus.set_hr;
        bus.alarm_min = bus.set_min + 6'd1;
      end
      cyc(1);
    end
    rst = 1'b0;
    bus.set_valid = 1'b0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rtc_bcd_clock.md
Name: rtc_bcd_clock

Overview:
- Parametrised successor to the team's fixed HH:MM:SS seven-segment clock.
- Divides the system clock down to a 1 Hz tick and keeps time in BCD digit counters.
- Adds a run enable, time-set load with legality checking, 12/24-hour display mode with leading-zero blanking, a minute-resolution alarm, and selectable segment polarity.
- Drives six seven-segment digits on the front-panel display.

Parameters:
- CLK_DIV, 50000000, clk cycles per one-second tick; legal range 1 to 2^32-1.
- SEG_ACTIVE_LOW, 1, 1 = segment lit when bit is 0; 0 = all segment outputs inverted.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active high.
- en  in  1  run enable; 0 freezes prescaler and time.
- mode_12h  in  1  1 = 12-hour display, 0 = 24-hour display.
- set_valid  in  1  load set_hr/set_min/set_sec this cycle.
- set_hr  in  5  binary hour, 0-23.
- set_min  in  6  binary minute, 0-59.
- set_sec  in  6  binary second, 0-59.
- alarm_en  in  1  alarm compare enable.
- alarm_hr  in  5  binary alarm hour, 0-23.
- alarm_min  in  6  binary alarm minute, 0-59.
- hr_m, hr_l, min_m, min_l, sec_m, sec_l  out  7 each  segment patterns for tens/units digits, bit6 = a … bit0 = g.
- pm  out  1  1 when displayed time is 12:00-23:59 and mode_12h = 1; otherwise 0.
- sec_tick  out  1  one-cycle pulse when time advances.
- alarm_hit  out  1  one-cycle pulse when alarm time is reached.
- set_err  out  1  one-cycle pulse when a set request is rejected.

Behaviour:
- Reset (rst = 1 at clock edge):
  - Prescaler = 0; all digit counters = 0 (00:00:00).
  - sec_tick = 0, alarm_hit = 0, set_err = 0.
  - Reset overrides set_valid and the tick.
- Prescaler:
  - While en = 1, counts 0 … CLK_DIV-1, then wraps to 0.
  - The tick event is the cycle in which en = 1 and prescaler = CLK_DIV-1.
  - CLK_DIV = 1 produces a tick every enabled cycle.
  - While en = 0, the prescaler holds.
- Time advance on a tick event, at the same edge:
  - sec_l 9 -> 0 carries into sec_m; sec_m 5 -> 0 carries into min_l; min_l carries into min_m; min_m 5 -> 0 carries into hours.
  - Hours run 00 … 23 -> 00.
  - 23:59:59 -> 00:00:00 in one tick.
  - Counters are never observed outside 0-9 / 0-5 / 00-23.
- sec_tick:
  - Registered; high for exactly the one cycle in which the new time is first visible on the outputs.
- Time set:
  - set_valid = 1 with set_hr ≤ 23, set_min ≤ 59 and set_sec ≤ 59: at that edge, binary inputs are converted to BCD and loaded, and the prescaler is cleared to 0.
  - The set takes priority over a coincident tick; no increment and no sec_tick that cycle.
  - Any field out of range: request ignored, time and prescaler unchanged (the tick still applies), set_err high for the following cycle.
  - Set operates regardless of en.
- Display decode:
  - Combinational from registered counters; no added latency.
  - Active-low digit table: 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100.
  - Blank = all segments off.
  - SEG_ACTIVE_LOW = 0 inverts all outputs, including blank.
- 12-hour mode (mode_12h = 1):
  - Displayed hour: 00 -> 12, 01-12 unchanged, 13-23 -> 01-11.
  - hr_m is blank when the displayed tens digit is 0.
  - Internal counters remain 24-hour.
  - mode_12h may change any cycle; the display follows combinationally with no effect on counting.
- Alarm:
  - alarm_hit is high for one cycle, coincident with sec_tick, when alarm_en = 1 and the tick produced hh:mm:ss = alarm_hr:alarm_min:00.
  - A time set landing on the alarm time does not fire the alarm.
  - alarm_hr/alarm_min values out of range never match.
- Reset mid-count:
  - The prescaler fraction is discarded; the first tick after reset release occurs CLK_DIV enabled cycles later.

Test Plan:
- CLK_DIV = 4, en = 1, after reset:
  - Stimulus: release reset, run 8 cycles.
  - Required: sec_tick pulses at cycles 4 and 8 after reset release; sec_l shows 0000001, then 1001111, then 0010010 (0, 1, 2); all outputs at reset show 00:00:00.
- Midnight rollover:
  - Stimulus: set 23:59:59 and wait for one tick.
  - Required: display reads 00:00:00 and sec_tick = 1.
  - Stimulus: repeat with mode_12h = 1.
  - Required: display reads 12:00:00 and pm = 0.
- Illegal set:
  - Stimulus: set_hr = 24, set_min = 10, set_sec = 0.
  - Required: time unchanged; set_err = 1 for exactly one cycle.
  - Stimulus: set_min = 60.
  - Required: same result.
- Set and tick in the same cycle:
  - Stimulus: set 10:20:30 in the tick cycle.
  - Required: display reads 10:20:30, no sec_tick; next tick occurs CLK_DIV cycles later and displays 10:20:31.
- 12-hour mode:
  - Stimulus: set 13:05:00 with mode_12h = 1.
  - Required: hr_m blank (1111111), hr_l = 1001111, pm = 1.
  - Stimulus: SEG_ACTIVE_LOW = 0 build, same setup.
  - Required: hr_m = 0000000.
- Alarm and enable:
  - Stimulus: alarm 07:30, set 07:29:59, tick.
  - Required: alarm_hit and sec_tick coincide for one cycle.
  - Stimulus: hold en = 0 for 10 cycles.
  - Required: no ticks and time frozen.
  - Stimulus: re-set 07:30:00 directly.
  - Required: no alarm_hit.
